// File: rtl/fetch_arbiter.sv
// fetch_arbiter: round-robin arbiter sharing one program-memory read port among
// NUM_REQ instruction fetchers. One transaction at a time: grant, issue the read,
// capture the returned word and pulse the response to the granted requester.
module fetch_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int ID_BITS   = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DATA_BITS-1:0]                resp_data,
    output logic                                mem_read_valid,
    output logic [ADDR_BITS-1:0]                mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [DATA_BITS-1:0]                mem_read_data,
    output logic                                busy,
    output logic [ID_BITS-1:0]                  grant_id
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ID_BITS-1:0]     r_rr_ptr;
    logic [ID_BITS-1:0]     r_grant_id;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_data;

    logic                   w_found;
    logic [ID_BITS-1:0]     w_sel;
    logic [ID_BITS-1:0]     w_idx;
    logic [ID_BITS-1:0]     w_ptr_next;
    int                     w_sum;

    // Round-robin pick: first requester at or after r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_idx = ID_BITS'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Pointer moves just past the requester that was served; explicit wrap keeps
    // non-power-of-two NUM_REQ correct.
    always_comb begin
        if (r_grant_id == ID_BITS'(NUM_REQ - 1)) w_ptr_next = '0;
        else                                     w_ptr_next = r_grant_id + 1'b1;
    end

    // State register; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and outputs; the response pulse is the only gated data path.
    always_comb begin
        w_next         = r_state;
        resp_valid     = '0;
        mem_read_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                mem_read_valid = 1'b1;
                if (mem_read_ready) w_next = S_RESPOND;
            end
            S_RESPOND: begin
                resp_valid[r_grant_id] = 1'b1;
                w_next                 = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Transaction latches: grant/address at selection, data on memory return,
    // pointer advance on response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant_id <= w_sel;
                r_addr     <= req_addr[w_sel];
            end
            if (r_state == S_ISSUE && mem_read_ready) r_data <= mem_read_data;
            if (r_state == S_RESPOND)                 r_rr_ptr <= w_ptr_next;
        end
    end

    assign resp_data        = r_data;
    assign mem_read_address = r_addr;
    assign busy             = (r_state != S_IDLE);
    assign grant_id         = r_grant_id;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_arbiter;
    localparam int NUM_REQ = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][7:0]   req_addr;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [15:0]               resp_data;
    logic                      mem_read_valid;
    logic [7:0]                mem_read_address;
    logic                      mem_read_ready;
    logic [15:0]               mem_read_data;
    logic                      busy;
    logic [1:0]                grant_id;

    fetch_arbiter #(.NUM_REQ(4), .ADDR_BITS(8), .DATA_BITS(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: answers a pending read after mem_delay waiting cycles.
    bit          mem_auto = 1'b1;
    int          mem_delay = 0;
    int          wait_cnt = 0;
    bit          use_fixed = 1'b0;
    logic [15:0] fixed_data = 16'h0;
    always @(posedge clk) begin
        #2;
        if (mem_auto) begin
            if (mem_read_valid) begin
                if (wait_cnt >= mem_delay) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = use_fixed ? fixed_data : {~mem_read_address, mem_read_address};
                    wait_cnt       = 0;
                end else begin
                    mem_read_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_read_ready = 1'b0;
                wait_cnt       = 0;
            end
        end
    end

    // Reference model: one outstanding transaction record.
    bit          m_act, m_got;
    logic [1:0]  m_id;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    int          m_ptr;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act = 0; m_got = 0; m_id = 0; m_addr = 0; m_data = 0; m_ptr = 0;
        end else if (!m_act) begin
            if (req_valid != 0) begin
                int win;
                win = 0;
                for (int k = NUM_REQ - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
                m_id = 2'(win);
                m_addr = req_addr[win];
                m_act = 1; m_got = 0;
            end
        end else if (!m_got) begin
            if (mem_read_ready) begin
                m_got = 1;
                m_data = mem_read_data;
            end
        end else begin
            m_act = 0; m_got = 0;
            m_ptr = (int'(m_id) + 1) % NUM_REQ;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0] exp_rv;
            exp_rv = m_got ? (4'b0001 << m_id) : 4'b0000;
            chk("busy", 32'(busy), 32'(m_act));
            chk("mem_read_valid", 32'(mem_read_valid), 32'(m_act && !m_got));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("resp_data", 32'(resp_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_id));
            if (m_act && !m_got) chk("mem_read_address", 32'(mem_read_address), 32'(m_addr));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin step(1); n++; end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Wait for a response pulse, return its index and drop that request.
    task automatic run_until_resp(output int id);
        int n = 0;
        id = -1;
        while (id < 0 && n < 40) begin
            step(1); n++;
            for (int i = 0; i < NUM_REQ; i++) if (resp_valid[i]) id = i;
        end
        if (id >= 0) req_valid[id] = 1'b0;
        else chk("resp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int id, n, got;
        int ids[5];
        int cycs[5];
        reset = 1'b0;
        req_valid = '0;
        req_addr = '{8'h40, 8'h30, 8'h20, 8'h10};
        mem_read_ready = 1'b0;
        mem_read_data = '0;
        step(1);
        cmp_en = 1'b1;

        // 1: reset held with all requesting
        req_valid = 4'b1111;
        step(3);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_resp", 32'(resp_valid), 32'd0);
        chk("t1_mrv", 32'(mem_read_valid), 32'd0);
        reset = 1'b1;
        step(1);
        chk("t1_grant0", 32'(grant_id), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd1);
        req_valid = '0;
        wait_idle();

        // 2: single request, memory answers after two wait cycles
        use_fixed = 1; fixed_data = 16'hBEEF; mem_delay = 2;
        req_addr[2] = 8'h3C;
        req_valid = 4'b0100;
        n = 0; id = -1;
        while (id < 0 && n < 20) begin
            step(1); n++;
            if (n == 1) begin
                chk("t2_addr", 32'(mem_read_address), 32'h3C);
                chk("t2_mrv", 32'(mem_read_valid), 32'd1);
            end
            if (resp_valid != 0) begin
                id = 2;
                chk("t2_resp_valid", 32'(resp_valid), 32'b0100);
                chk("t2_resp_data", 32'(resp_data), 32'hBEEF);
                chk("t2_latency", 32'(n), 32'd4);
                req_valid = '0;
            end
        end
        chk("t2_seen", 32'(id), 32'd2);
        step(1);
        chk("t2_pulse_1cyc", 32'(resp_valid), 32'd0);
        chk("t2_data_hold", 32'(resp_data), 32'hBEEF);
        wait_idle();
        use_fixed = 0; mem_delay = 0;

        // 3: all requesting continuously, immediate memory
        do_reset();
        req_valid = 4'b1111;
        n = 0; got = 0;
        while (got < 5 && n < 60) begin
            step(1); n++;
            if (resp_valid != 0) begin
                for (int i = 0; i < NUM_REQ; i++) if (resp_valid[i]) ids[got] = i;
                cycs[got] = cyc;
                got++;
                if (got == 5) req_valid = '0;
            end
        end
        chk("t3_count", 32'(got), 32'd5);
        for (int i = 0; i < 5; i++) chk("t3_order", 32'(ids[i]), 32'(i % 4));
        for (int i = 1; i < 5; i++) chk("t3_interval", 32'(cycs[i] - cycs[i-1]), 32'd3);
        wait_idle();

        // 4: wrap (pointer is 1 here; serve requester 2 to move it to 3)
        req_valid = 4'b0100;
        run_until_resp(id); chk("t4_pre", 32'(id), 32'd2);
        wait_idle();
        req_valid = 4'b1001;
        run_until_resp(id); chk("t4_first", 32'(id), 32'd3);
        run_until_resp(id); chk("t4_second", 32'(id), 32'd0);
        wait_idle();
        req_valid = 4'b1001;
        run_until_resp(id); chk("t4_ptr1_first", 32'(id), 32'd3);
        run_until_resp(id); chk("t4_ptr1_second", 32'(id), 32'd0);
        wait_idle();

        // 5: requester 1 withdraws during ISSUE (pointer is 1)
        mem_delay = 2;
        req_valid = 4'b0111;
        step(1);
        chk("t5_grant", 32'(grant_id), 32'd1);
        req_valid[1] = 1'b0;
        run_until_resp(id); chk("t5_resp1", 32'(id), 32'd1);
        run_until_resp(id); chk("t5_next2", 32'(id), 32'd2);
        run_until_resp(id); chk("t5_then0", 32'(id), 32'd0);
        wait_idle();
        mem_delay = 0;

        // 6: reset during ISSUE, then a stray ready
        mem_auto = 0; mem_read_ready = 1'b0;
        req_valid = 4'b0100;
        step(2);
        chk("t6_in_issue", 32'(mem_read_valid), 32'd1);
        reset = 1'b0; req_valid = '0;
        step(1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_mrv", 32'(mem_read_valid), 32'd0);
        reset = 1'b1;
        mem_read_ready = 1'b1; mem_read_data = 16'h1234;
        step(1);
        chk("t6_stray_resp", 32'(resp_valid), 32'd0);
        chk("t6_stray_busy", 32'(busy), 32'd0);
        mem_read_ready = 1'b0;
        step(1);
        chk("t6_stray_resp2", 32'(resp_valid), 32'd0);
        chk("t6_stray_data", 32'(resp_data), 32'd0);
        mem_auto = 1;
        step(1);
        req_valid = 4'b1111;
        step(1);
        chk("t6_ptr0", 32'(grant_id), 32'd0);
        run_until_resp(id); chk("t6_resp0", 32'(id), 32'd0);
        req_valid = '0;
        wait_idle();

        step(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
